// File: rtl/cr_cddip_sa_dump_pkg.sv
// Shared types and constants for the statistics-aggregator dump engine.
package cr_cddip_sa_dump_pkg;

  localparam int unsigned SA_DUMP_IDX_W = 6;
  localparam int unsigned SA_DUMP_SEQ_W = 8;
  localparam int unsigned SA_DUMP_VAL_W = 50;

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StWait,
    StStream,
    StDone
  } sa_dump_state_e;

  // One streamed word: {index, seq, value} packs into exactly 64 bits.
  typedef struct packed {
    logic [SA_DUMP_IDX_W-1:0] index;
    logic [SA_DUMP_SEQ_W-1:0] seq;
    logic [SA_DUMP_VAL_W-1:0] value;
  } sa_dump_word_t;

endpackage

// File: rtl/cr_cddip_sa_dump_ffs.sv
// Find-first-set over mask bits strictly above base_i.
module cr_cddip_sa_dump_ffs #(
  parameter int unsigned N    = 64,
  parameter int unsigned IdxW = 6
) (
  input  logic [N-1:0]    mask_i,
  input  logic [IdxW-1:0] base_i,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  // Scan high to low so the lowest qualifying bit is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(base_i))) begin
        found_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/cr_cddip_sa_dump.sv
// Snapshot-and-stream dump engine for the statistics counters.
module cr_cddip_sa_dump
  import cr_cddip_sa_dump_pkg::*;
#(
  parameter int unsigned N_CNTR   = 64,
  parameter int unsigned CNTR_W   = 50,
  parameter int unsigned SNAP_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CNTR-1:0][CNTR_W-1:0]  sa_snapshot,
  input  logic                           cfg_dump_en,
  input  logic [31:0]                    cfg_dump_interval,
  input  logic [N_CNTR-1:0]              cfg_dump_mask,
  input  logic                           sw_dump_req,
  output logic                           dump_snap,
  output logic                           dump_valid,
  input  logic                           dump_ready,
  output logic [63:0]                    dump_data,
  output logic                           dump_last,
  output logic                           dump_busy,
  output logic                           dump_done,
  output logic [15:0]                    dump_overrun
);

  localparam int unsigned WaitW = (SNAP_LAT > 1) ? $clog2(SNAP_LAT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SNAP_LAT - 1);

  sa_dump_state_e             state_q, state_d;
  logic [31:0]                timer_q, timer_d;
  logic [SA_DUMP_SEQ_W-1:0]   seq_q, seq_d;
  logic [15:0]                ovr_q, ovr_d;
  logic [N_CNTR-1:0]          mask_q, mask_d;
  logic [SA_DUMP_IDX_W-1:0]   idx_q, idx_d;
  logic [WaitW-1:0]           wait_q, wait_d;

  logic                       timer_run, tick, trig;
  logic                       nxt_found;
  logic [SA_DUMP_IDX_W-1:0]   nxt_idx;
  sa_dump_word_t              word;

  cr_cddip_sa_dump_ffs #(
    .N    (N_CNTR),
    .IdxW (SA_DUMP_IDX_W)
  ) u_ffs (
    .mask_i  (mask_q),
    .base_i  (idx_q),
    .found_o (nxt_found),
    .idx_o   (nxt_idx)
  );

  // Periodic timer: tick on interval-1, then restart from zero.
  always_comb begin
    timer_run = cfg_dump_en && (cfg_dump_interval != 32'd0);
    tick      = timer_run && (timer_q == cfg_dump_interval - 32'd1);
    timer_d   = (timer_run && !tick) ? timer_q + 32'd1 : 32'd0;
    trig      = sw_dump_req | tick;
  end

  // Dump sequencing, overrun accounting and next-index selection.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    if (trig && (state_q != StIdle) && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StSnap;
          mask_d  = cfg_dump_mask;
          idx_d   = '0;
        end
      end
      StSnap: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          if (mask_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StStream;
            // idx_q is still 0 here, so the ffs only covers bits 1 and up.
            idx_d   = mask_q[0] ? '0 : nxt_idx;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StStream: begin
        if (dump_ready) begin
          if (nxt_found) idx_d = nxt_idx;
          else           state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        seq_d   = seq_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    word.index   = idx_q;
    word.seq     = seq_q;
    word.value   = SA_DUMP_VAL_W'(sa_snapshot[idx_q]);
    dump_snap    = (state_q == StSnap);
    dump_valid   = (state_q == StStream);
    dump_last    = dump_valid && !nxt_found;
    dump_busy    = (state_q != StIdle);
    dump_done    = (state_q == StDone);
    dump_data    = dump_valid ? word : 64'd0;
    dump_overrun = ovr_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      seq_q   <= '0;
      ovr_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_cr_cddip_sa_dump.sv
// Scoreboard bench for cr_cddip_sa_dump against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_cr_cddip_sa_dump;

  localparam int unsigned N_CNTR   = 64;
  localparam int unsigned CNTR_W   = 50;
  localparam int unsigned SNAP_LAT = 2;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [N_CNTR-1:0][CNTR_W-1:0] sa_snapshot;
  logic                          cfg_dump_en;
  logic [31:0]                   cfg_dump_interval;
  logic [N_CNTR-1:0]             cfg_dump_mask;
  logic                          sw_dump_req;
  logic                          dump_snap, dump_valid, dump_ready, dump_last;
  logic                          dump_busy, dump_done;
  logic [63:0]                   dump_data;
  logic [15:0]                   dump_overrun;

  always #5 clk = ~clk;

  cr_cddip_sa_dump #(
    .N_CNTR   (N_CNTR),
    .CNTR_W   (CNTR_W),
    .SNAP_LAT (SNAP_LAT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sa_snapshot       (sa_snapshot),
    .cfg_dump_en       (cfg_dump_en),
    .cfg_dump_interval (cfg_dump_interval),
    .cfg_dump_mask     (cfg_dump_mask),
    .sw_dump_req       (sw_dump_req),
    .dump_snap         (dump_snap),
    .dump_valid        (dump_valid),
    .dump_ready        (dump_ready),
    .dump_data         (dump_data),
    .dump_last         (dump_last),
    .dump_busy         (dump_busy),
    .dump_done         (dump_done),
    .dump_overrun      (dump_overrun)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb_q[$];

  // Model: a dump is busy for 1+SNAP_LAT pre-stream cycles, one cycle per
  // transferred word, then one done cycle.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_pre = 0;
  int          m_words[$];
  logic [7:0]  m_seq = '0;
  logic [15:0] m_ovr = '0;
  logic [31:0] m_timer = '0;
  int          cyc = 0;
  bit          m_tick, m_trig;
  int          n0, dummy;
  exp_t        e_new;

  bit          chk_en = 1'b0;
  int          ready_mode = 0;
  bit          ready_val = 1'b1;
  bit          mask_wiggle = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          snap_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_pre   = 0;
      m_words.delete();
      sb_q.delete();
      m_seq   = '0;
      m_ovr   = '0;
      m_timer = '0;
    end else begin
      m_tick = cfg_dump_en && (cfg_dump_interval != 0) && (m_timer == cfg_dump_interval - 1);
      m_trig = sw_dump_req || m_tick;
      if (m_busy && m_trig && m_ovr != 16'hFFFF) m_ovr++;
      if (!m_busy) begin
        if (m_trig) begin
          m_busy = 1'b1;
          m_pre  = 1 + SNAP_LAT;
          n0     = sb_q.size();
          for (int i = 0; i < N_CNTR; i++) begin
            if (cfg_dump_mask[i]) begin
              m_words.push_back(i);
              e_new.data = {6'(i), m_seq, sa_snapshot[i]};
              e_new.last = 1'b0;
              sb_q.push_back(e_new);
            end
          end
          if (sb_q.size() > n0) sb_q[sb_q.size()-1].last = 1'b1;
        end
      end else if (m_pre > 0) begin
        m_pre--;
        if (m_pre == 0 && m_words.size() == 0) m_done = 1'b1;
      end else if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
        m_seq++;
      end else if (dump_ready) begin
        dummy = m_words.pop_front();
        if (m_words.size() == 0) m_done = 1'b1;
      end
      if (cfg_dump_en && cfg_dump_interval != 0) m_timer = m_tick ? 32'd0 : m_timer + 32'd1;
      else m_timer = 32'd0;
    end
  end

  // Monitor: control outputs against the model every cycle, words against the scoreboard.
  bit          e_valid;
  logic [20:0] exp_c, act_c;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (dump_snap) snap_cnt++;
    if (chk_en) begin
      e_valid = m_busy && (m_pre == 0) && !m_done;
      exp_c   = {m_busy, m_busy && (m_pre == 1 + SNAP_LAT), e_valid,
                 e_valid && (m_words.size() == 1), m_done, m_ovr};
      act_c   = {dump_busy, dump_snap, dump_valid, dump_last, dump_done, dump_overrun};
      checks++;
      if (act_c !== exp_c) begin
        errors++;
        $display("FAIL ctrl @%0t: busy/snap/valid/last/done/ovr got %h expected %h",
                 $time, act_c, exp_c);
      end
    end
    if (dump_valid && dump_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL word @%0t: unexpected transfer data=%h expected none", $time, dump_data);
      end else begin
        e_mon = sb_q.pop_front();
        if (dump_data !== e_mon.data || dump_last !== e_mon.last) begin
          errors++;
          $display("FAIL word @%0t: got data=%h last=%b expected data=%h last=%b",
                   $time, dump_data, dump_last, e_mon.data, e_mon.last);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      sw_dump_req = 1'b0;
      case (ready_mode)
        0:       dump_ready = ready_val;
        1:       dump_ready = pat[cyc % 4];
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (mask_wiggle) cfg_dump_mask = {$urandom, $urandom};
    end
  endtask

  task automatic pulse_sw();
    sw_dump_req = 1'b1;
    step(1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (m_busy && k < 5000) begin
      step(1);
      k++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL %s: dump still busy after 5000 cycles, required idle", tag);
    end
    step(1);
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic new_snapshot();
    for (int i = 0; i < N_CNTR; i++) sa_snapshot[i] = CNTR_W'({$urandom, $urandom});
  endtask

  initial begin
    int k;
    int snap_base;
    logic [15:0] ovr_base;
    sw_dump_req       = 1'b0;
    cfg_dump_en       = 1'b0;
    cfg_dump_interval = 32'd0;
    cfg_dump_mask     = '0;
    dump_ready        = 1'b1;
    new_snapshot();

    // Reset state
    step(3);
    check_val("reset_outputs", {dump_snap, dump_valid, dump_last, dump_busy, dump_done,
              dump_overrun}, 64'd0);
    check_val("reset_data", dump_data, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step(2);

    // All counters, ready held high
    cfg_dump_mask = '1;
    ready_mode = 0;
    ready_val  = 1'b1;
    pulse_sw();
    wait_idle("full_dump");

    // Sparse mask with ready toggling 1,0,0,1
    new_snapshot();
    cfg_dump_mask = 64'h8000_0000_0000_0005;
    ready_mode = 1;
    pulse_sw();
    wait_idle("sparse_dump");

    // Empty mask
    cfg_dump_mask = '0;
    ready_mode = 0;
    pulse_sw();
    wait_idle("empty_dump");

    // Random masks, random backpressure, mask changing mid-dump
    for (int n = 0; n < 20; n++) begin
      new_snapshot();
      case ($urandom_range(0, 3))
        0:       cfg_dump_mask = {$urandom, $urandom};
        1:       cfg_dump_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2:       cfg_dump_mask = 64'd1 << $urandom_range(0, 63);
        default: cfg_dump_mask = {1'b1, 63'($urandom)};
      endcase
      ready_mode = 2;
      pulse_sw();
      mask_wiggle = 1'b1;
      wait_idle("random_dump");
      mask_wiggle = 1'b0;
    end

    // Periodic timer, then a short interval that overruns
    ready_mode = 0;
    ready_val  = 1'b1;
    cfg_dump_mask = 64'h0000_00FF_0000_0F0F;
    cfg_dump_interval = 32'd200;
    cfg_dump_en = 1'b1;
    step(650);
    cfg_dump_en = 1'b0;
    step(1);
    cfg_dump_mask = '1;
    cfg_dump_interval = 32'd10;
    cfg_dump_en = 1'b1;
    step(300);
    cfg_dump_en = 1'b0;
    wait_idle("timer_dump");
    check_val("overrun_count", {48'd0, dump_overrun}, {48'd0, m_ovr});

    // Software request coincident with a timer tick
    cfg_dump_mask = 64'h0000_0000_0000_0030;
    cfg_dump_interval = 32'd50;
    cfg_dump_en = 1'b1;
    k = 0;
    while (m_timer != 32'd49 && k < 100) begin
      step(1);
      k++;
    end
    snap_base = snap_cnt;
    ovr_base  = m_ovr;
    sw_dump_req = 1'b1;
    step(1);
    cfg_dump_en = 1'b0;
    wait_idle("coincident_dump");
    check_val("coincident_snaps", 64'(snap_cnt - snap_base), 64'd1);
    check_val("coincident_ovr", {48'd0, dump_overrun}, {48'd0, ovr_base});

    // Reset in the middle of streaming at index 20
    new_snapshot();
    cfg_dump_mask = '1;
    pulse_sw();
    k = 0;
    while (!(dump_valid && dump_data[63:58] == 6'd20) && k < 200) begin
      step(1);
      k++;
    end
    check_val("reached_idx20", {63'd0, dump_valid}, 64'd1);
    rst_n = 1'b0;
    step(1);
    check_val("midreset_outputs", {dump_snap, dump_valid, dump_last, dump_busy, dump_done,
              dump_overrun}, 64'd0);
    check_val("midreset_data", dump_data, 64'd0);
    rst_n = 1'b1;
    step(1);
    cfg_dump_mask = 64'h0000_0001_0000_0002;
    pulse_sw();
    wait_idle("post_reset_dump");

    // 256 empty dumps wrap the sequence number
    cfg_dump_mask = '0;
    for (int n = 0; n < 256; n++) begin
      pulse_sw();
      wait_idle("wrap_dump");
    end
    cfg_dump_mask = 64'h4000_0000_0000_0100;
    pulse_sw();
    wait_idle("after_wrap_dump");

    // Overrun saturation: tick every cycle while a dump is stalled
    chk_en = 1'b0;
    cfg_dump_mask = '1;
    ready_val = 1'b0;
    cfg_dump_interval = 32'd1;
    cfg_dump_en = 1'b1;
    step(66000);
    check_val("overrun_sat", {48'd0, dump_overrun}, 64'h0000_0000_0000_FFFF);
    check_val("overrun_model", {48'd0, dump_overrun}, {48'd0, m_ovr});
    cfg_dump_en = 1'b0;
    ready_val = 1'b1;
    step(1);
    chk_en = 1'b1;
    wait_idle("sat_drain");
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
